dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache.sv | 174 +++++++++++++++++
 tb/tb_dcache.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Lines hold four words. Read hits complete with zero wait states. A read
// miss refills the whole line from memory, then the held request is served
// from the array. Stores always go to memory. On a store hit, the enabled
// bytes are also merged into the cached word.
module dcache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cache_rd,
    input  logic                  cache_wr,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [DATA_WIDTH-1:0] cache_wr_data,
    input  logic [BE_WIDTH-1:0]   cache_wr_be,
    output logic [DATA_WIDTH-1:0] cache_data,
    output logic                  cache_waitrequest,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [BE_WIDTH-1:0]   mem_wr_be,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_waitrequest
);

    localparam int NUM_LINES = 2 ** INDEX_BITS;
    localparam int NUM_WORDS = NUM_LINES * 4;
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Replace the bytes selected by be in old_word with the bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (be[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                result[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [1:0]              count_r;
    logic [NUM_LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0]     tag_mem_r  [0:NUM_LINES-1];
    logic [DATA_WIDTH-1:0]   data_mem_r [0:NUM_WORDS-1];

    logic [1:0]              offset_s;
    logic [INDEX_BITS-1:0]   index_s;
    logic [TAG_BITS-1:0]     tag_s;
    logic                    hit_s;
    logic [DATA_WIDTH-1:0]   stored_word_s;
    logic                    read_miss_s;
    logic                    refill_accept_s;
    logic                    write_done_s;

    assign offset_s      = cache_addr[1:0];
    assign index_s       = cache_addr[INDEX_BITS+1:2];
    assign tag_s         = cache_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign stored_word_s = data_mem_r[{index_s, offset_s}];
    assign hit_s         = valid_r[index_s] && (tag_mem_r[index_s] == tag_s);

    // A store takes priority over a simultaneous load, so only a pure load can miss.
    assign read_miss_s     = (state_r == IDLE) && cache_rd && !cache_wr && !hit_s;
    assign refill_accept_s = (state_r == REFILL) && !mem_waitrequest;
    assign write_done_s    = (state_r == WRITE) && !mem_waitrequest;

    // State register, refill word counter and line valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= 2'd0;
            valid_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == IDLE) begin
                count_r <= 2'd0;
            end else if (refill_accept_s) begin
                count_r <= count_r + 2'd1;
            end else begin
                count_r <= count_r;
            end
            // The line is invalid while it is refilled. A refill that is
            // aborted therefore never leaves a line that is half old, half new.
            if (read_miss_s) begin
                valid_r[index_s] <= 1'b0;
            end else if (refill_accept_s && (count_r == 2'd3)) begin
                valid_r[index_s] <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Tag and data arrays: refill words, first-word tag capture, store-hit merge.
    always_ff @(posedge clock) begin
        if (!reset && refill_accept_s) begin
            data_mem_r[{index_s, count_r}] <= mem_rd_data;
            if (count_r == 2'd0) begin
                tag_mem_r[index_s] <= tag_s;
            end
        end else if (!reset && write_done_s && hit_s) begin
            data_mem_r[{index_s, offset_s}] <= merge_bytes(stored_word_s, cache_wr_data, cache_wr_be);
        end
    end

    // Next-state and requester/memory handshake outputs.
    always_comb begin
        state_next_s      = state_r;
        cache_waitrequest = 1'b0;
        cache_data        = stored_word_s;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = cache_addr;
        mem_wr_data       = cache_wr_data;
        mem_wr_be         = cache_wr_be;
        case (state_r)
            IDLE: begin
                if (cache_wr) begin
                    cache_waitrequest = 1'b1;
                    state_next_s      = WRITE;
                end else if (cache_rd && !hit_s) begin
                    cache_waitrequest = 1'b1;
                    state_next_s      = REFILL;
                end else begin
                    cache_waitrequest = 1'b0;
                    state_next_s      = IDLE;
                end
            end
            REFILL: begin
                cache_waitrequest = 1'b1;
                mem_rd            = 1'b1;
                mem_addr          = {tag_s, index_s, count_r};
                if (refill_accept_s && (count_r == 2'd3)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REFILL;
                end
            end
            WRITE: begin
                mem_wr = 1'b1;
                if (mem_waitrequest) begin
                    cache_waitrequest = 1'b1;
                    state_next_s      = WRITE;
                end else begin
                    cache_waitrequest = 1'b0;
                    state_next_s      = IDLE;
                end
            end
            default: begin
                cache_waitrequest = 1'b1;
                state_next_s      = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache. A responsive word memory model sits on the
// memory port. It has a configurable wait count per request and merges
// stores byte-wise. A vector table holds requests with hand-computed
// results. Hand-written sequences cover the reset-related cases.
module tb_dcache;

    logic        clock;
    logic        reset;
    logic        cache_rd;
    logic        cache_wr;
    logic [31:0] cache_addr;
    logic [31:0] cache_wr_data;
    logic [3:0]  cache_wr_be;
    logic [31:0] cache_data;
    logic        cache_waitrequest;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic [31:0] mem_rd_data;
    logic        mem_waitrequest;

    dcache dut (
        .clock(clock), .reset(reset),
        .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_addr(cache_addr),
        .cache_wr_data(cache_wr_data), .cache_wr_be(cache_wr_be),
        .cache_data(cache_data), .cache_waitrequest(cache_waitrequest),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be),
        .mem_rd_data(mem_rd_data), .mem_waitrequest(mem_waitrequest)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- memory model ----------------
    bit [31:0] wmem  [0:16383];
    bit        wflag [0:16383];
    int        wait_cfg;
    int        wait_cnt;
    int        beats;
    int        rd_cyc;
    int        wr_cyc;
    logic      both_hi;
    logic [31:0] rd_q [$];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h103) return 32'hA0 + {30'd0, a[1:0]};
        return {16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    initial begin
        wait_cnt = 0; beats = 0; rd_cyc = 0; wr_cyc = 0; both_hi = 1'b0;
    end

    assign mem_waitrequest = (mem_rd || mem_wr) && (wait_cnt < wait_cfg);

    always_comb begin
        mem_rd_data = wflag[mem_addr[13:0]] ? wmem[mem_addr[13:0]] : def_word(mem_addr);
    end

    always @(posedge clock) begin
        if (mem_rd || mem_wr) begin
            if (mem_waitrequest) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
        end
        if (mem_rd) rd_cyc <= rd_cyc + 1;
        if (mem_rd && !mem_waitrequest) begin
            rd_q.push_back(mem_addr);
            beats <= beats + 1;
        end
        if (mem_wr) begin
            wr_cyc <= wr_cyc + 1;
            if (!mem_waitrequest) begin
                wmem[mem_addr[13:0]]  <= tb_merge(mem_rd_data, mem_wr_data, mem_wr_be);
                wflag[mem_addr[13:0]] <= 1'b1;
            end
        end
        if (mem_rd && mem_wr) both_hi <= 1'b1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_n;
        logic [31:0] exp_data;
        int          exp_cycles;
        int          exp_beats;
        int          exp_wr_cycles;
    } vec_t;

    // Apply one request, hold it until accepted, then check latency, data and memory traffic.
    task automatic do_vec(input vec_t v, input string nm);
        int          cyc;
        int          rb, rc, wc, qs;
        logic        done;
        logic [31:0] got;
        wait_cfg      = v.wait_n;
        cache_rd      = v.rd;
        cache_wr      = v.wr;
        cache_addr    = v.addr;
        cache_wr_data = v.wdata;
        cache_wr_be   = v.be;
        rb = beats; rc = rd_cyc; wc = wr_cyc; qs = rd_q.size();
        cyc = 0; done = 1'b0; got = 32'd0;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (!cache_waitrequest) begin
                done = 1'b1;
                got  = cache_data;
            end
        end
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        @(posedge clock);
        #1;
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        chk({nm, "_cycles"}, cyc, v.exp_cycles);
        if (v.rd && !v.wr) chk({nm, "_data"}, got, v.exp_data);
        chk({nm, "_beats"}, beats - rb, v.exp_beats);
        chk({nm, "_rdcyc"}, rd_cyc - rc, v.exp_beats * (v.wait_n + 1));
        chk({nm, "_wrcyc"}, wr_cyc - wc, v.exp_wr_cycles);
        if (v.exp_beats == 4 && rd_q.size() >= qs + 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s_addr%0d", nm, i), rd_q[qs+i], {v.addr[31:2], 2'(i)});
        end
    endtask

    vec_t vecs [14];

    initial begin
        int n;
        int b0;
        vec_t extra;

        // rd wr addr wdata be wait exp_data cycles beats wrcycles
        vecs[0]  = '{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 1, 32'h000000A0, 10, 4, 0};
        vecs[1]  = '{1'b1, 1'b0, 32'h102,  32'h0,        4'h0, 1, 32'h000000A2, 1,  0, 0};
        vecs[2]  = '{1'b0, 1'b1, 32'h101,  32'h11223344, 4'h3, 0, 32'h0,        2,  0, 1};
        // low two bytes come from the store, upper two from the cached 0x000000A1
        vecs[3]  = '{1'b1, 1'b0, 32'h101,  32'h0,        4'h0, 0, 32'h00003344, 1,  0, 0};
        vecs[4]  = '{1'b1, 1'b0, 32'h500,  32'h0,        4'h0, 0, 32'hBEEF0500, 6,  4, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'h100,  32'h0,        4'h0, 0, 32'h000000A0, 6,  4, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'h101,  32'h0,        4'h0, 0, 32'h00003344, 1,  0, 0};
        vecs[7]  = '{1'b0, 1'b1, 32'h2000, 32'hCAFEF00D, 4'hF, 0, 32'h0,        2,  0, 1};
        vecs[8]  = '{1'b1, 1'b0, 32'h2000, 32'h0,        4'h0, 0, 32'hCAFEF00D, 6,  4, 0};
        vecs[9]  = '{1'b1, 1'b0, 32'h2003, 32'h0,        4'h0, 1, 32'hBEEF2003, 1,  0, 0};
        vecs[10] = '{1'b1, 1'b1, 32'h2001, 32'h55667788, 4'hC, 0, 32'h0,        2,  0, 1};
        vecs[11] = '{1'b1, 1'b0, 32'h2001, 32'h0,        4'h0, 0, 32'h55662001, 1,  0, 0};
        vecs[12] = '{1'b0, 1'b1, 32'h2002, 32'h01020304, 4'hF, 2, 32'h0,        4,  0, 3};
        vecs[13] = '{1'b1, 1'b0, 32'h2002, 32'h0,        4'h0, 0, 32'h01020304, 1,  0, 0};

        reset = 1'b1; cache_rd = 1'b0; cache_wr = 1'b0;
        cache_addr = 32'd0; cache_wr_data = 32'd0; cache_wr_be = 4'd0; wait_cfg = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_wait", {31'd0, cache_waitrequest}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) do_vec(vecs[i], $sformatf("v%0d", i));

        // Reset after two of four refill words have been accepted.
        wait_cfg = 0;
        cache_addr = 32'h1234;
        cache_rd = 1'b1;
        b0 = beats;
        n = 0;
        while ((beats - b0) < 2 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("mid_refill_beats", beats - b0, 2);
        chk("mid_refill_rd", {31'd0, mem_rd}, 32'd1);
        reset = 1'b1;
        cache_rd = 1'b0;
        @(negedge clock);
        chk("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("abort_wait", {31'd0, cache_waitrequest}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        extra = '{1'b1, 1'b0, 32'h1234, 32'h0, 4'h0, 0, 32'hBEEF1234, 6, 4, 0};
        do_vec(extra, "after_abort");
        // Reset cleared every valid bit, so a line that hit before must now be refilled.
        extra = '{1'b1, 1'b0, 32'h2002, 32'h0, 4'h0, 0, 32'h01020304, 6, 4, 0};
        do_vec(extra, "post_rst_miss");

        chk("rd_wr_exclusive", {31'd0, both_hi}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
